// File: rtl/span_stepper.sv
// span_stepper: pops one triangle record from the FIFO and decides whether
// it is finished. If not, it emits the visible span for the current line and
// writes the record back, stepped to the next line when it was active.
// Record layout, LSB upward: attr[0..NATTR-1] ({val, step, nstep} each),
// yend, ymid, ycurr, mbot, mtop, mlong, xmid, x2, x1. The top XW+XF bits of
// the REC_W word are reserved; they are carried through unchanged.
module span_stepper #(
  parameter int XW    = 10,
  parameter int XF    = 10,
  parameter int YW    = 10,
  parameter int NATTR = 4,
  parameter int AW    = 22,
  localparam int REC_W = 3*(XW+XF) + XW + 3*(XW+XF+1) + 3*YW + NATTR*(3*AW+2)
) (
  input  logic                      clk100,
  input  logic                      rst,
  input  logic [REC_W-1:0]          fifo_rd_data,
  input  logic                      fifo_empty,
  output logic                      fifo_pop,
  output logic [REC_W-1:0]          fifo_wr_data,
  output logic                      fifo_push,
  input  logic                      fifo_full,
  input  logic                      line_done,
  input  logic                      next_frame,
  input  logic                      next_line,
  output logic                      span_valid,
  input  logic                      span_ready,
  output logic [XW-1:0]             span_x1,
  output logic [XW-1:0]             span_x2,
  output logic [NATTR*AW-1:0]       span_attr,
  output logic [NATTR*(AW+1)-1:0]   span_nstep,
  output logic                      retired,
  output logic [YW-1:0]             ycounter
);

  localparam int XFW      = XW + XF;
  localparam int SW       = XFW + 1;
  localparam int ATW      = 3*AW + 2;
  localparam int YEND_LO  = NATTR*ATW;
  localparam int YMID_LO  = YEND_LO + YW;
  localparam int YCURR_LO = YMID_LO + YW;
  localparam int MBOT_LO  = YCURR_LO + YW;
  localparam int MTOP_LO  = MBOT_LO + SW;
  localparam int MLONG_LO = MTOP_LO + SW;
  localparam int XMID_LO  = MLONG_LO + SW;
  localparam int X2_LO    = XMID_LO + XW;
  localparam int X1_LO    = X2_LO + XFW;

  typedef enum logic [1:0] {IDLE, DECIDE, EMIT, PUSH} state_t;

  state_t             state, state_n;
  logic [REC_W-1:0]   cur_rec;
  logic [REC_W-1:0]   out_rec;
  logic [REC_W-1:0]   stepped;
  logic               active_q;
  logic               active_c;
  logic               visible;
  logic [YW-1:0]      ycurr_c;
  logic [YW-1:0]      yn;
  logic [XFW-1:0]     x1_n;
  logic [XFW-1:0]     x2_n;
  logic [AW-1:0]      attr_val;
  logic [AW:0]        attr_step;
  logic [AW+1:0]      attr_sum;
  logic [AW-1:0]      attr_new;

  assign ycurr_c  = cur_rec[YCURR_LO +: YW];
  assign active_c = (ycurr_c <= ycounter) && (ycurr_c < cur_rec[YEND_LO +: YW]);
  assign visible  = cur_rec[X1_LO+XF +: XW] != cur_rec[X2_LO+XF +: XW];

  assign fifo_wr_data = out_rec;
  assign span_x1      = cur_rec[X1_LO+XF +: XW];
  assign span_x2      = cur_rec[X2_LO+XF +: XW];

  // Build the record advanced by one line: x edges stepped, y bumped, attrs clamped.
  always_comb begin
    stepped   = cur_rec;
    attr_val  = '0;
    attr_step = '0;
    attr_sum  = '0;
    attr_new  = '0;
    yn   = ycurr_c + YW'(1);
    x1_n = cur_rec[X1_LO +: XFW] + cur_rec[MLONG_LO +: XFW];
    if (yn < cur_rec[YMID_LO +: YW])
      x2_n = cur_rec[X2_LO +: XFW] + cur_rec[MTOP_LO +: XFW];
    else if (yn == cur_rec[YMID_LO +: YW])
      x2_n = {cur_rec[XMID_LO +: XW], {XF{1'b0}}};
    else
      x2_n = cur_rec[X2_LO +: XFW] + cur_rec[MBOT_LO +: XFW];
    stepped[X1_LO +: XFW]   = x1_n;
    stepped[X2_LO +: XFW]   = x2_n;
    stepped[YCURR_LO +: YW] = yn;
    for (int i = 0; i < NATTR; i++) begin
      attr_val  = cur_rec[i*ATW + 2*AW + 2 +: AW];
      attr_step = cur_rec[i*ATW + AW + 1 +: AW + 1];
      attr_sum  = {2'b00, attr_val} + {attr_step[AW], attr_step};
      if (attr_sum[AW+1])
        attr_new = '0;
      else if (attr_sum[AW])
        attr_new = '1;
      else
        attr_new = attr_sum[AW-1:0];
      stepped[i*ATW + 2*AW + 2 +: AW] = attr_new;
    end
  end

  // Unpack the current attribute values and their per-pixel steps for the span.
  always_comb begin
    span_attr  = '0;
    span_nstep = '0;
    for (int i = 0; i < NATTR; i++) begin
      span_attr[i*AW +: AW]         = cur_rec[i*ATW + 2*AW + 2 +: AW];
      span_nstep[i*(AW+1) +: AW+1]  = cur_rec[i*ATW +: AW + 1];
    end
  end

  // State register; a new frame throws away whatever record is in flight.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state and handshake strobes; next_frame and reset silence everything.
  always_comb begin
    state_n    = state;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;
    span_valid = 1'b0;
    retired    = 1'b0;
    case (state)
      IDLE: begin
        if (line_done && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = DECIDE;
        end
      end
      DECIDE: begin
        if (ycurr_c >= cur_rec[YEND_LO +: YW]) begin
          retired = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (active_q && visible) begin
          span_valid = 1'b1;
          if (span_ready)
            state_n = PUSH;
        end else begin
          state_n = PUSH;
        end
      end
      PUSH: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (next_frame || rst) begin
      fifo_pop   = 1'b0;
      fifo_push  = 1'b0;
      span_valid = 1'b0;
      retired    = 1'b0;
      state_n    = IDLE;
    end
  end

  // Capture the popped record, then latch the write-back image during DECIDE.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      cur_rec  <= '0;
      out_rec  <= '0;
      active_q <= 1'b0;
    end else if (!next_frame) begin
      if (fifo_pop)
        cur_rec <= fifo_rd_data;
      if (state == DECIDE) begin
        active_q <= active_c;
        out_rec  <= active_c ? stepped : cur_rec;
      end
    end
  end

  // Current raster line; a frame start wins over a simultaneous line advance.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst)
      ycounter <= '0;
    else if (next_frame)
      ycounter <= '0;
    else if (next_line)
      ycounter <= ycounter + YW'(1);
  end

endmodule

// File: tb/tb_span_stepper.sv
// tb_span_stepper: directed and random records driven through span_stepper,
// compared cycle by cycle against an arithmetic model of the stepping rules.
module tb_span_stepper;

  localparam int XW = 10, XF = 10, YW = 10, NATTR = 4, AW = 22;
  localparam int XFW = XW + XF;
  localparam int SW = XFW + 1;
  localparam int ATW = 3*AW + 2;
  localparam int REC_W = 3*XFW + XW + 3*SW + 3*YW + NATTR*ATW;
  localparam int YEND_LO = NATTR*ATW;
  localparam int YCURR_LO = YEND_LO + 2*YW;
  localparam int X2_LO = YEND_LO + 3*YW + 3*SW + XW;
  localparam int X1_LO = X2_LO + XFW;

  logic                    clk100;
  logic                    rst;
  logic [REC_W-1:0]        fifo_rd_data;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [REC_W-1:0]        fifo_wr_data;
  logic                    fifo_push;
  logic                    fifo_full;
  logic                    line_done;
  logic                    next_frame;
  logic                    next_line;
  logic                    span_valid;
  logic                    span_ready;
  logic [XW-1:0]           span_x1;
  logic [XW-1:0]           span_x2;
  logic [NATTR*AW-1:0]     span_attr;
  logic [NATTR*(AW+1)-1:0] span_nstep;
  logic                    retired;
  logic [YW-1:0]           ycounter;

  span_stepper #(.XW(XW), .XF(XF), .YW(YW), .NATTR(NATTR), .AW(AW)) dut (
    .clk100(clk100), .rst(rst),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_wr_data(fifo_wr_data), .fifo_push(fifo_push), .fifo_full(fifo_full),
    .line_done(line_done), .next_frame(next_frame), .next_line(next_line),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_x1(span_x1), .span_x2(span_x2), .span_attr(span_attr), .span_nstep(span_nstep),
    .retired(retired), .ycounter(ycounter)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_ycnt = 0;

  logic [XFW-1:0] r_pad, r_x1, r_x2;
  logic [XW-1:0]  r_xmid;
  logic [SW-1:0]  r_mlong, r_mtop, r_mbot;
  logic [YW-1:0]  r_ycurr, r_ymid, r_yend;
  logic [AW-1:0]  r_val   [NATTR];
  logic [AW:0]    r_step  [NATTR];
  logic [AW:0]    r_nstep [NATTR];
  logic [REC_W-1:0] push_seen;

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NATTR*AW-1:0] cur_vals();
    logic [NATTR*AW-1:0] v;
    for (int i = 0; i < NATTR; i++) v[i*AW +: AW] = r_val[i];
    return v;
  endfunction

  function automatic logic [NATTR*(AW+1)-1:0] cur_nsteps();
    logic [NATTR*(AW+1)-1:0] v;
    for (int i = 0; i < NATTR; i++) v[i*(AW+1) +: AW+1] = r_nstep[i];
    return v;
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(input logic [XFW-1:0] x1, input logic [XFW-1:0] x2,
                                                input logic [YW-1:0] yc, input logic [NATTR*AW-1:0] vals);
    logic [REC_W-1:0] r;
    r = {r_pad, x1, x2, r_xmid, r_mlong, r_mtop, r_mbot, yc, r_ymid, r_yend, {NATTR*ATW{1'b0}}};
    for (int i = 0; i < NATTR; i++) r[i*ATW +: ATW] = {vals[i*AW +: AW], r_step[i], r_nstep[i]};
    return r;
  endfunction

  // Reference: what the record written back to the FIFO should be.
  function automatic logic [REC_W-1:0] model_push();
    int t, s;
    logic [XFW-1:0] nx1, nx2;
    logic [YW-1:0] yn;
    logic [NATTR*AW-1:0] nv;
    if (int'(r_ycurr) > model_ycnt) return pack_rec(r_x1, r_x2, r_ycurr, cur_vals());
    t = int'(r_x1) + int'($signed(r_mlong));
    nx1 = t[XFW-1:0];
    yn = r_ycurr + YW'(1);
    if (yn < r_ymid) t = int'(r_x2) + int'($signed(r_mtop));
    else if (yn == r_ymid) t = int'(r_xmid) * (1 << XF);
    else t = int'(r_x2) + int'($signed(r_mbot));
    nx2 = t[XFW-1:0];
    for (int i = 0; i < NATTR; i++) begin
      s = int'(r_val[i]) + int'($signed(r_step[i]));
      if (s < 0) s = 0;
      if (s > (1 << AW) - 1) s = (1 << AW) - 1;
      nv[i*AW +: AW] = s[AW-1:0];
    end
    return pack_rec(nx1, nx2, yn, nv);
  endfunction

  task automatic randRec();
    r_pad = XFW'($urandom); r_x1 = XFW'($urandom); r_x2 = XFW'($urandom);
    r_xmid = XW'($urandom);
    r_mlong = SW'($urandom); r_mtop = SW'($urandom); r_mbot = SW'($urandom);
    r_ycurr = YW'($urandom); r_ymid = YW'($urandom); r_yend = YW'($urandom);
    for (int i = 0; i < NATTR; i++) begin
      case ($urandom_range(0, 3))
        0: r_val[i] = '0;
        1: r_val[i] = '1;
        default: r_val[i] = AW'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) r_step[i] = (AW+1)'($urandom);
      else r_step[i] = (AW+1)'($signed($urandom_range(0, 64)) - 32);
      r_nstep[i] = (AW+1)'($urandom);
    end
  endtask

  // Restart the frame (next_line held alongside, which must lose) then advance n lines.
  task automatic setLines(input int n);
    next_frame = 1'b1; next_line = 1'b1;
    @(posedge clk100); #1;
    next_frame = 1'b0;
    for (int i = 0; i < n; i++) begin
      next_line = 1'b1;
      @(posedge clk100); #1;
    end
    next_line = 1'b0;
    model_ycnt = n % (1 << YW);
    @(negedge clk100);
    checkOutput("ycounter_set", REC_W'(ycounter), REC_W'(model_ycnt[YW-1:0]));
    @(posedge clk100); #1;
  endtask

  // One record: pop, optional span with ready delay d, push with f full cycles.
  // abort_mode 1 = next_frame+next_line at abort_cyc, 2 = async reset after abort_cyc.
  task automatic applyStimulus(input int d, input int f, input int abort_mode, input int abort_cyc);
    logic [REC_W-1:0] rec, exp_rec;
    logic [3:0] exp_flags;
    logic ret, act, vis;
    int ps, last;
    rec = pack_rec(r_x1, r_x2, r_ycurr, cur_vals());
    exp_rec = model_push();
    ret = r_yend <= r_ycurr;
    act = int'(r_ycurr) <= model_ycnt;
    vis = act && (r_x1[XFW-1:XF] != r_x2[XFW-1:XF]);
    ps = vis ? 3 + d : 3;
    last = ret ? 2 : ps + f + 1;
    push_seen = '0;
    fifo_rd_data = rec;
    for (int c = 0; c <= last; c++) begin
      line_done = (c == 0);
      fifo_empty = (c != 0);
      span_ready = (c >= 2 + d);
      fifo_full = (c < ps + f);
      next_frame = 1'b0;
      next_line = 1'b0;
      exp_flags = {c == 0, !ret && c == ps + f, !ret && vis && c >= 2 && c <= 2 + d, ret && c == 1};
      if (abort_mode == 1 && c == abort_cyc) begin
        next_frame = 1'b1; next_line = 1'b1; fifo_full = 1'b0;
        exp_flags = 4'b0000;
      end
      @(negedge clk100);
      if (c == 0) checkOutput("ycounter", REC_W'(ycounter), REC_W'(model_ycnt[YW-1:0]));
      checkOutput($sformatf("pop_push_valid_retired_c%0d", c),
                  REC_W'({fifo_pop, fifo_push, span_valid, retired}), REC_W'(exp_flags));
      if (exp_flags[1])
        checkOutput($sformatf("span_fields_c%0d", c), REC_W'({span_x1, span_x2, span_attr, span_nstep}),
                    REC_W'({r_x1[XFW-1:XF], r_x2[XFW-1:XF], cur_vals(), cur_nsteps()}));
      if (!ret && c >= ps && c <= ps + f && !(abort_mode == 1 && c >= abort_cyc))
        checkOutput($sformatf("wr_data_c%0d", c), fifo_wr_data, exp_rec);
      if (fifo_push) push_seen = fifo_wr_data;
      if (abort_mode == 1 && c == abort_cyc) begin
        @(posedge clk100); #1;
        next_frame = 1'b0; next_line = 1'b0; line_done = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
        model_ycnt = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk100);
          checkOutput($sformatf("after_frame_k%0d", k),
                      REC_W'({fifo_pop, fifo_push, span_valid, retired, ycounter}), '0);
          @(posedge clk100); #1;
        end
        return;
      end
      if (abort_mode == 2 && c == abort_cyc) begin
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_mid_strobes_span",
                    REC_W'({fifo_pop, fifo_push, span_valid, retired, ycounter, span_x1, span_x2, span_attr, span_nstep}), '0);
        checkOutput("reset_mid_wr_data", fifo_wr_data, '0);
        @(posedge clk100); #1;
        rst = 1'b0; model_ycnt = 0;
        line_done = 1'b0; fifo_empty = 1'b1; span_ready = 1'b0; fifo_full = 1'b0;
        return;
      end
      @(posedge clk100); #1;
    end
    line_done = 1'b0; fifo_empty = 1'b1; span_ready = 1'b0; fifo_full = 1'b0;
  endtask

  initial begin
    logic [REC_W-1:0] orig;
    rst = 1'b1; next_frame = 1'b0; next_line = 1'b0;
    span_ready = 1'b1; fifo_full = 1'b0;
    randRec();
    fifo_rd_data = pack_rec(r_x1, r_x2, r_ycurr, cur_vals());
    line_done = 1'b1; fifo_empty = 1'b0;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    checkOutput("reset_strobes_span",
                REC_W'({fifo_pop, fifo_push, span_valid, retired, ycounter, span_x1, span_x2, span_attr, span_nstep}), '0);
    checkOutput("reset_wr_data", fifo_wr_data, '0);
    @(posedge clk100); #1;
    rst = 1'b0; line_done = 1'b0; fifo_empty = 1'b1; span_ready = 1'b0;
    @(posedge clk100); #1;

    $display("[TB] step case");
    setLines(10);
    randRec();
    r_x1 = 20'h4B000; r_x2 = 20'h4B000; r_mlong = 21'h1FFDF3; r_mtop = 21'h000423;
    r_ycurr = 10; r_ymid = 300; r_yend = 400;
    applyStimulus(0, 0, 0, 0);
    checkOutput("step_x1", REC_W'(push_seen[X1_LO +: XFW]), REC_W'(20'h4ADF3));
    checkOutput("step_x2", REC_W'(push_seen[X2_LO +: XFW]), REC_W'(20'h4B423));
    checkOutput("step_ycurr", REC_W'(push_seen[YCURR_LO +: YW]), REC_W'(11));

    $display("[TB] clamp case");
    setLines(50);
    randRec();
    r_ycurr = 30; r_yend = 200;
    r_val[0] = 22'h3FFFFF; r_step[0] = 23'h000001;
    r_val[1] = 22'h000000; r_step[1] = 23'h7FFFFF;
    r_val[2] = 22'h000100; r_step[2] = 23'h000010;
    applyStimulus(1, 1, 0, 0);
    checkOutput("clamp_hi", REC_W'(push_seen[0*ATW + 2*AW + 2 +: AW]), REC_W'(22'h3FFFFF));
    checkOutput("clamp_lo", REC_W'(push_seen[1*ATW + 2*AW + 2 +: AW]), REC_W'(22'h000000));
    checkOutput("clamp_mid", REC_W'(push_seen[2*ATW + 2*AW + 2 +: AW]), REC_W'(22'h000110));

    $display("[TB] retire case");
    randRec();
    r_ycurr = 400; r_yend = 400;
    applyStimulus(2, 0, 0, 0);

    $display("[TB] backpressure case");
    randRec();
    r_x1 = 20'h10000; r_x2 = 20'h20000; r_ycurr = 40; r_yend = 300;
    applyStimulus(4, 5, 0, 0);

    $display("[TB] inactive case");
    setLines(5);
    randRec();
    r_x1 = 20'h10000; r_x2 = 20'h30000; r_ycurr = 20; r_yend = 100;
    orig = pack_rec(r_x1, r_x2, r_ycurr, cur_vals());
    applyStimulus(2, 2, 0, 0);
    checkOutput("inactive_passthrough", push_seen, orig);

    $display("[TB] frame during push");
    setLines(7);
    randRec();
    r_x1 = 20'h01000; r_x2 = 20'h0F000; r_ycurr = 3; r_yend = 100;
    applyStimulus(0, 4, 1, 5);

    $display("[TB] reset during emit");
    setLines(9);
    randRec();
    r_x1 = 20'h02000; r_x2 = 20'h0A000; r_ycurr = 4; r_yend = 100;
    applyStimulus(3, 0, 2, 3);

    $display("[TB] ycounter wrap");
    setLines((1 << YW) + 1);

    $display("[TB] random records");
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) setLines($urandom_range(0, 60));
      randRec();
      r_ycurr = YW'($urandom_range(0, model_ycnt + 8));
      r_yend = YW'($urandom_range(0, 120));
      if ($urandom_range(0, 1) == 1) r_ymid = r_ycurr + YW'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) r_x2[XFW-1:XF] = r_x1[XFW-1:XF];
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/span_stepper.md
SPAN_STEPPER -- requirements
Module: span_stepper

Interface
REQ-001 SHALL have parameter XW, default 10, meaning integer bits of an X coordinate.
REQ-002 SHALL have parameter XF, default 10, meaning fraction bits of X; X fields are XW+XF bits wide and X slopes are XW+XF+1 bits signed.
REQ-003 SHALL have parameter YW, default 10, meaning width of Y fields and of the line counter.
REQ-004 SHALL have parameter NATTR, default 4, meaning number of interpolated attribute channels.
REQ-005 SHALL have parameter AW, default 22, meaning attribute value width (unsigned); step and span-delta fields are AW+1 bits signed.
REQ-006 SHALL define REC_W = 3(XW+XF) + XW + 3(XW+XF+1) + 3YW + NATTR(3AW+2); the record layout, MSB first, SHALL be {x1, x2, xmid, mlong, mtop, mbot, ycurr, ymid, yend, attr[NATTR-1] .. attr[0]}, with each attr = {val, step, nstep}.
REQ-007 SHALL have port clk100, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have ports fifo_rd_data (input, REC_W), fifo_empty (input, 1) and fifo_pop (output, 1): the first-word-fall-through read side of the triangle FIFO.
REQ-010 SHALL have ports fifo_wr_data (output, REC_W), fifo_push (output, 1) and fifo_full (input, 1): the write side of the same FIFO.
REQ-011 SHALL have ports line_done (input, 1: rasterizer idle), next_frame (input, 1) and next_line (input, 1).
REQ-012 SHALL have ports span_valid (output, 1) and span_ready (input, 1); span_x1 and span_x2 (output, XW each); span_attr (output, NATTR*AW); span_nstep (output, NATTR*(AW+1)).
REQ-013 SHALL have ports retired (output, 1: one-cycle pulse when a record is dropped) and ycounter (output, YW).

Function
REQ-014 SHALL implement states IDLE, DECIDE, EMIT and PUSH.
REQ-015 In IDLE, when line_done=1 and fifo_empty=0: assert fifo_pop for exactly that cycle, capture fifo_rd_data, and go to DECIDE; otherwise stay in IDLE.
REQ-016 In DECIDE, set active = (ycurr <= ycounter) && (ycurr < yend).
REQ-017 In DECIDE, if ycurr >= yend: drop the record, pulse retired for one cycle, and return to IDLE with no push; otherwise go to EMIT.
REQ-018 In DECIDE, register the stepped record:
- x1 + mlong, and ycurr + 1 (= yn);
- x2 = x2 + mtop if yn < ymid; {xmid, XF zeros} if yn == ymid; otherwise x2 + mbot.
REQ-019 X and Y arithmetic SHALL wrap modulo the field width.
REQ-020 Per attribute, form val + step in AW+1 bits and clamp to [0, 2^AW - 1]:
- positive overflow yields all ones;
- negative result yields zero.
REQ-021 In EMIT, if active and x1[int] != x2[int]: hold span_valid=1 with stable span_x1=x1[XF+:XW], span_x2, span_attr=current vals and span_nstep until span_ready=1, then go to PUSH.
REQ-022 In EMIT, if the span is not visible, go to PUSH on the next cycle without asserting span_valid.
REQ-023 In PUSH, present fifo_wr_data (the stepped record if active, else the unmodified captured record) and assert fifo_push only in cycles where fifo_full=0.
REQ-024 In PUSH, fifo_wr_data SHALL stay stable while fifo_full=1; after the accepted push, return to IDLE.
REQ-025 ycounter SHALL increment on next_line and wrap at 2^YW.
REQ-026 next_frame is synchronous and highest priority: ycounter becomes 0, state becomes IDLE, the in-flight record is discarded, and no push, pop or span is issued in that cycle.
REQ-027 When next_frame and next_line are both high, next_frame SHALL win and ycounter becomes 0.
REQ-028 fifo_pop, fifo_push and span_valid SHALL never be asserted in the same cycle.
REQ-029 Steady-state latency from pop to push SHALL be 3 cycles when no backpressure is applied.

Reset
REQ-030 While rst=1, the block SHALL hold state IDLE; ycounter, fifo_pop, fifo_push, span_valid, retired, fifo_wr_data and all span outputs at 0.
REQ-031 Reset asserted mid-operation SHALL discard the record; after rst falls, operation SHALL resume from IDLE on the first clock edge.

Verification
REQ-032 Step case: ycounter=10; record x1=x2=0x4B000, mlong=0x1FFDF3, mtop=0x000423, ycurr=10, ymid=300, yend=400 -> no span_valid (x1 int == x2 int); push x1=0x4ADF3, x2=0x4B423, ycurr=11, exactly 3 cycles after pop.
REQ-033 Clamp case: attr val=0x3FFFFF, step=+1 -> pushed 0x3FFFFF; val=0, step=-1 -> pushed 0; val=0x100, step=+0x10 -> pushed 0x110.
REQ-034 Retire case: ycurr=400, yend=400 -> one retired pulse, no push, no span, back in IDLE.
REQ-035 Backpressure case: fifo_full=1 for 5 cycles in PUSH and span_ready delayed 4 cycles in EMIT -> fifo_wr_data and span outputs stable; fifo_push rises only in the first cycle with fifo_full=0.
REQ-036 Inactive case: ycurr=20, ycounter=5 -> no span; pushed record identical to the popped record.
REQ-037 Frame and reset case: next_frame and next_line asserted together while in PUSH -> ycounter=0, IDLE, no push; rst asserted mid-EMIT -> all outputs 0 asynchronously.
